// File: rtl/fifo_bank_pkg.sv
// Shared constants and helpers for the output FIFO bank.
package fifo_bank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;

  localparam int FLG_FULL  = 0;
  localparam int FLG_EMPTY = 1;
  localparam int FLG_AFULL = 2;
  localparam int FLG_AEMPT = 3;
  localparam int FLG_WRERR = 4;
  localparam int FLG_RDERR = 5;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_bank_out_if.sv
// Host bus plus core push port of the output FIFO bank.
interface fifo_bank_out_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 6
);
  logic              sel;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] din;
  logic              err_clr;
  logic              push;
  logic [CH_W-1:0]   push_ch;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] dout;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [5:0]        fifo_flag;

  modport master (
    output sel, wr, address, din, err_clr,
    output push, push_ch, push_data,
    input  dout, fifo_cnt, fifo_flag
  );

  modport slave (
    input  sel, wr, address, din, err_clr,
    input  push, push_ch, push_data,
    output dout, fifo_cnt, fifo_flag
  );
endinterface

// File: rtl/fifo_chan.sv
// One output channel: storage, pointers, count,
// thresholds and sticky error flags.
module fifo_chan
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4,
  localparam int PW    = clog2(DEPTH),
  localparam int CW    = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              wr_drop_i,
  input  logic              pop_i,
  input  logic              clr_i,
  output logic              pop_ok_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CW-1:0]     cnt_o,
  output logic [5:0]        flags_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_err_q, rd_err_d;
  logic              full, empty;
  logic              do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // a successful pop frees a slot for a same-cycle push
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    wptr_d   = wptr_q + PW'(do_push);
    rptr_d   = rptr_q + PW'(do_pop);
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    wr_err_d = wr_err_q & ~clr_i;
    rd_err_d = rd_err_q & ~clr_i;
    if ((push_i & ~do_push) | wr_drop_i)
      wr_err_d = 1'b1;
    if (pop_i & empty)
      rd_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_data_i;
  end

  assign pop_ok_o  = do_pop;
  assign rd_data_o = mem_q[rptr_q];
  assign cnt_o     = cnt_q;

  always_comb begin
    flags_o            = '0;
    flags_o[FLG_FULL]  = full;
    flags_o[FLG_EMPTY] = empty;
    flags_o[FLG_AFULL] = (cnt_q >= CW'(AF_LVL));
    flags_o[FLG_AEMPT] = (cnt_q <= CW'(AE_LVL));
    flags_o[FLG_WRERR] = wr_err_q;
    flags_o[FLG_RDERR] = rd_err_q;
  end

endmodule

// File: rtl/fifo_bank_out.sv
// Bank of NUM_CH output FIFOs behind the host bus.
// Optional irq output: define FIFO_BANK_IRQ_EN.
module fifo_bank_out
  import fifo_bank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h20,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef FIFO_BANK_IRQ_EN
  input  logic [NUM_CH-1:0] irq_mask,
  output logic              irq,
`endif
  fifo_bank_out_if.slave    bus
);

  localparam int CH_W = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int CW   = clog2(DEPTH + 1);

  logic [ADDR_W:0]   off;
  logic              hit;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-1:0] pop_ok;
  logic [DATA_W-1:0] rd_w  [NUM_CH];
  logic [CW-1:0]     cnt_w [NUM_CH];
  logic [5:0]        flg_w [NUM_CH];
  logic [DATA_W-1:0] dout_q, dout_d;

  assign off = {1'b0, bus.address} - {1'b0, BASE_ADDR};
  assign hit = bus.sel
             & (bus.address >= BASE_ADDR)
             & (off < (ADDR_W+1)'(NUM_CH));
  assign ch  = off[CH_W-1:0];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [CH_W-1:0] K = CH_W'(k);
    logic bus_wr, core, pop, clr;

    assign bus_wr = hit & bus.wr & (ch == K);
    assign core   = bus.push & (bus.push_ch == K);
    assign pop    = hit & ~bus.wr & (ch == K);
    assign clr    = hit & bus.err_clr & (ch == K);

    // core push wins a collision; the bus word is lost
    fifo_chan #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .push_i      (core | bus_wr),
      .push_data_i (core ? bus.push_data : bus.din),
      .wr_drop_i   (core & bus_wr),
      .pop_i       (pop),
      .clr_i       (clr),
      .pop_ok_o    (pop_ok[k]),
      .rd_data_o   (rd_w[k]),
      .cnt_o       (cnt_w[k]),
      .flags_o     (flg_w[k])
    );
  end

  always_comb begin
    dout_d = dout_q;
    if (|pop_ok) dout_d = rd_w[ch];
  end

  always_ff @(posedge clk) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign bus.dout      = dout_q;
  assign bus.fifo_cnt  = hit ? cnt_w[ch] : '0;
  assign bus.fifo_flag = hit ? flg_w[ch] : '0;

`ifdef FIFO_BANK_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      irq_d |= irq_mask[k] & (~flg_w[k][FLG_EMPTY]
             | flg_w[k][FLG_WRERR] | flg_w[k][FLG_RDERR]);
  end

  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_fifo_bank_out.sv
// Directed bench for fifo_bank_out (default build,
// four channels of 32 x 32-bit words at 8'h20).
module tb_fifo_bank_out;

  logic clk = 1'b0;
  logic reset;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fifo_bank_out_if #(
    .DATA_W (32),
    .ADDR_W (8),
    .CH_W   (2),
    .CNT_W  (6)
  ) bus ();

`ifdef FIFO_BANK_IRQ_EN
  logic [3:0] irq_mask = '0;
  logic       irq;
`endif

  fifo_bank_out dut (
    .clk      (clk),
    .reset    (reset),
`ifdef FIFO_BANK_IRQ_EN
    .irq_mask (irq_mask),
    .irq      (irq),
`endif
    .bus      (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.sel     = 1'b0;
    bus.wr      = 1'b0;
    bus.address = 8'h00;
    bus.din     = '0;
    bus.err_clr = 1'b0;
    bus.push    = 1'b0;
    bus.push_ch = '0;
    bus.push_data = '0;
  endtask

  task automatic bus_op(input logic w,
                        input logic [7:0] a,
                        input logic [31:0] d);
    idle();
    bus.sel = 1'b1;
    bus.wr = w;
    bus.address = a;
    bus.din = d;
    tick();
    idle();
  endtask

  // look at comb status without letting an edge pass
  task automatic peek(input string tag,
                      input logic [7:0] a,
                      input logic [5:0] ecnt,
                      input logic [5:0] eflg);
    bus.sel = 1'b1;
    bus.wr = 1'b0;
    bus.address = a;
    #1;
    chk({tag, ".cnt"}, 64'(bus.fifo_cnt), 64'(ecnt));
    chk({tag, ".flg"}, 64'(bus.fifo_flag), 64'(eflg));
    bus.sel = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    peek("rst_ch1", 8'h21, 6'd0, 6'b001010);
    chk("rst_dout", 64'(bus.dout), 64'd0);

    for (int i = 1; i <= 32; i++)
      bus_op(1'b1, 8'h21, 32'(i));
    bus_op(1'b1, 8'h21, 32'd99);
    peek("full_ch1", 8'h21, 6'd32, 6'b010101);

    for (int i = 1; i <= 32; i++) begin
      bus_op(1'b0, 8'h21, 32'd0);
      chk($sformatf("rd%0d", i), 64'(bus.dout), 64'(i));
    end
    bus_op(1'b0, 8'h21, 32'd0);
    chk("rd_under", 64'(bus.dout), 64'd32);
    peek("empty_ch1", 8'h21, 6'd0, 6'b111010);

    idle();
    bus.push = 1'b1;
    bus.push_ch = 2'd1;
    bus.push_data = 32'hAAAA_0001;
    bus.sel = 1'b1;
    bus.wr = 1'b1;
    bus.address = 8'h21;
    bus.din = 32'hBBBB_0002;
    tick();
    idle();
    peek("coll", 8'h21, 6'd1, 6'b111000);

    bus.sel = 1'b1;
    bus.wr = 1'b0;
    bus.address = 8'h21;
    bus.err_clr = 1'b1;
    tick();
    idle();
    chk("coll_rd", 64'(bus.dout), 64'hAAAA_0001);
    peek("clr", 8'h21, 6'd0, 6'b001010);

    for (int i = 0; i < 32; i++) begin
      bus.push = 1'b1;
      bus.push_ch = 2'd0;
      bus.push_data = 32'(100 + i);
      tick();
    end
    idle();
    peek("full_ch0", 8'h20, 6'd32, 6'b000101);

    bus.sel = 1'b1;
    bus.wr = 1'b0;
    bus.address = 8'h20;
    bus.push = 1'b1;
    bus.push_ch = 2'd0;
    bus.push_data = 32'h0000_DEAD;
    tick();
    idle();
    chk("rp_full_rd", 64'(bus.dout), 64'd100);
    peek("rp_full", 8'h20, 6'd32, 6'b000101);

    for (int i = 1; i < 32; i++) begin
      bus_op(1'b0, 8'h20, 32'd0);
      chk($sformatf("ch0_rd%0d", i), 64'(bus.dout), 64'(100 + i));
    end
    bus_op(1'b0, 8'h20, 32'd0);
    chk("ch0_last", 64'(bus.dout), 64'h0000_DEAD);

    bus.sel = 1'b1;
    bus.wr = 1'b0;
    bus.address = 8'h22;
    bus.push = 1'b1;
    bus.push_ch = 2'd2;
    bus.push_data = 32'd55;
    tick();
    idle();
    chk("rp_empty_dout", 64'(bus.dout), 64'h0000_DEAD);
    peek("rp_empty", 8'h22, 6'd1, 6'b101000);

    bus.sel = 1'b1;
    bus.wr = 1'b1;
    bus.address = 8'h24;
    bus.din = 32'd7;
    #1;
    chk("miss.cnt", 64'(bus.fifo_cnt), 64'd0);
    chk("miss.flg", 64'(bus.fifo_flag), 64'd0);
    tick();
    idle();
    peek("miss_ch0", 8'h20, 6'd0, 6'b001010);
    peek("miss_ch1", 8'h21, 6'd0, 6'b001010);
    peek("miss_ch2", 8'h22, 6'd1, 6'b101000);
    peek("miss_ch3", 8'h23, 6'd0, 6'b001010);
    bus_op(1'b0, 8'h24, 32'd0);
    chk("miss_dout", 64'(bus.dout), 64'h0000_DEAD);

    for (int i = 0; i < 5; i++)
      bus_op(1'b1, 8'h23, 32'(200 + i));
    peek("burst_ch3", 8'h23, 6'd5, 6'b000000);
    bus.sel = 1'b1;
    bus.wr = 1'b1;
    bus.address = 8'h23;
    bus.din = 32'd300;
    bus.push = 1'b1;
    bus.push_ch = 2'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    peek("mrst_ch0", 8'h20, 6'd0, 6'b001010);
    peek("mrst_ch2", 8'h22, 6'd0, 6'b001010);
    peek("mrst_ch3", 8'h23, 6'd0, 6'b001010);
    chk("mrst_dout", 64'(bus.dout), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fifo_bank_out.md
Name: fifo_bank_out

Overview:
- Parametrised bank of NUM_CH independent output FIFOs behind the shared sel/wr/address bus.
- The compute core pushes results into channels through a dedicated push port. The host reads them, or writes directly, through the bus.
- Successor to the fixed two-FIFO output top. Generalises width, depth and channel count, and adds almost-full/empty thresholds, sticky error flags and defined same-cycle collision rules.

Parameters:
DATA_W, 32, data word width
DEPTH, 32, words per channel; power of 2, at least 4
NUM_CH, 4, number of channels (1..16)
ADDR_W, 8, bus address width
BASE_ADDR, 8'h20, bus address of channel 0; channel k is at BASE_ADDR+k
AF_LVL, DEPTH-4, almost-full asserted when count >= AF_LVL
AE_LVL, 4, almost-empty asserted when count <= AE_LVL

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
sel  in  1  bus select
wr  in  1  bus direction: 1 = write, 0 = read (valid when sel=1)
address  in  ADDR_W  bus address
din  in  DATA_W  bus write data
err_clr  in  1  clears sticky errors of the addressed channel (when sel=1)
push  in  1  core push strobe
push_ch  in  clog2(NUM_CH)  core push channel
push_data  in  DATA_W  core push data
dout  out  DATA_W  registered bus read data
fifo_cnt  out  clog2(DEPTH+1)  count of the addressed channel
fifo_flag  out  6  status of the addressed channel: [0]full [1]empty [2]almost_full [3]almost_empty [4]wr_err [5]rd_err

Behaviour:
- Reset, on a clk edge with reset=1:
  - all pointers and counts are 0;
  - dout = 0;
  - sticky errors are 0;
  - every channel is empty; fifo_flag for a hit channel = 6'b001010.
- Reset mid-operation discards all stored data. No memory clear is required.
- Hit: sel=1 and BASE_ADDR <= address < BASE_ADDR+NUM_CH; ch = address-BASE_ADDR.
- With no hit, or sel=0:
  - no bus access occurs;
  - fifo_cnt = 0 and fifo_flag = 0;
  - dout holds its value.
- fifo_cnt and fifo_flag are combinational from the addressed channel's registered state (state before the current edge).
- Bus write (hit, wr=1): pushes din into ch.
  - If ch is full: the word is dropped and wr_err is set.
- Core push: pushes push_data into push_ch.
  - If push_ch is full: the word is dropped and wr_err of push_ch is set.
  - push_ch >= NUM_CH: ignored.
- Write collision: bus write and core push to the same channel in one cycle. Core wins; the bus word is dropped; wr_err is set.
- Bus read (hit, wr=0): pops ch. dout takes the popped word at the same edge, so data is visible one cycle after the read request.
  - If ch is empty: dout holds and rd_err is set.
- Read and core push on the same channel in one cycle:
  - Full channel: both succeed and count is unchanged.
  - Empty channel: the read fails (no bypass) with rd_err set; the push succeeds; count becomes 1.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- err_clr clears both sticky bits of ch. An error raised in the same cycle wins, so the bit stays set.
- Ordering is strict FIFO per channel. Channels are fully independent.

Optional Feature:
FIFO_BANK_IRQ_EN
- Defined:
  - adds input irq_mask[NUM_CH-1:0] and output irq;
  - irq is registered; it equals OR over k of (mask[k] & (!empty[k] | wr_err[k] | rd_err[k])) and resets to 0.
- Undefined: no irq or irq_mask ports, no extra logic.

Decomposition:
- Package fifo_bank_pkg holds:
  - flag bit index constants (FLG_FULL=0 .. FLG_RDERR=5);
  - the clog2 function;
  - the default DEPTH/DATA_W constants.
- Sub-module fifo_chan: single-channel storage, pointers, count, thresholds and sticky errors. It has push/pop/clr inputs and exposes rd_data, cnt and flags. Instantiated NUM_CH times via generate; the top does address decode, arbitration and muxing.

Test Plan:
1. Reset, then sel=1, address=8'h21 -> fifo_cnt=0, fifo_flag=6'b001010, dout=0.
2. 32 bus writes to 8'h21 (1..32), then a 33rd write -> cnt=32, flag[0]=1, flag[2]=1, flag[4]=1; the 33rd word is absent from read-back.
3. 33 reads at 8'h21 -> dout=1..32 in order, each one cycle after its request; the 33rd read leaves dout=32 and sets flag[5]=1 with flag[1]=1.
4. Same cycle: core push ch1=A and bus write 8'h21=B -> only A stored; cnt=1; wr_err=1. Then err_clr=1 -> flag[5:4]=0.
5. Full ch0 plus read and push in the same cycle -> cnt stays 32 and the head word is returned. Empty ch2 plus read and push -> rd_err=1, cnt=1.
6. address=8'h24 (NUM_CH=4) with wr=1 -> no channel changes; fifo_flag=0. Reset asserted mid-burst -> all counts 0 on the next cycle.
